// File: rtl/reg_file.sv
// Register file: 2^ADDR_W x DATA_W storage, two combinational read ports, a debug read port,
// one write port and a 16-bit committed-write counter.
// Register 0 is hard-wired to zero. Synchronous active-high reset clears storage and counter.
// Optional macro RF_BYPASS_EN forwards wb_data to rf_ra/rf_rb on a same-cycle index match
// (debug port is never bypassed).
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cu_rs,
  input  logic [ADDR_W-1:0] cu_rt,
  input  logic              cu_wreg,
  input  logic [ADDR_W-1:0] cu_wn,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rf_ra,
  output logic [DATA_W-1:0] rf_rb,
  input  logic [ADDR_W-1:0] dbg_idx,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       rf_wcnt
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] regs_d [Depth];
  logic [15:0]       wcnt_q, wcnt_d;
  logic              wr_en;

  // Next-state: commit a write only to a non-zero index; per-entry compare so an unknown
  // index cannot disturb entries it does not match.
  always_comb begin
    wr_en  = cu_wreg && (cu_wn != '0);
    regs_d = regs_q;
    wcnt_d = wcnt_q;
    for (int unsigned i = 1; i < Depth; i++) begin
      if (wr_en && (cu_wn == ADDR_W'(i))) begin
        regs_d[i] = wb_data;
      end
    end
    if (wr_en) begin
      wcnt_d = wcnt_q + 16'd1;
    end
    regs_d[0] = '0;
  end

  // State register; reset overrides any concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      wcnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      wcnt_q <= wcnt_d;
    end
  end

  // Combinational read ports; index 0 always reads zero.
  always_comb begin
    rf_ra    = (cu_rs   == '0) ? '0 : regs_q[cu_rs];
    rf_rb    = (cu_rt   == '0) ? '0 : regs_q[cu_rt];
    dbg_data = (dbg_idx == '0) ? '0 : regs_q[dbg_idx];
`ifdef RF_BYPASS_EN
    if (wr_en && (cu_rs == cu_wn)) begin
      rf_ra = wb_data;
    end
    if (wr_en && (cu_rt == cu_wn)) begin
      rf_rb = wb_data;
    end
`endif
  end

  assign rf_wcnt = wcnt_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (default parameters).
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  cu_rs = '0;
  logic [4:0]  cu_rt = '0;
  logic        cu_wreg = 1'b0;
  logic [4:0]  cu_wn = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] rf_ra;
  logic [31:0] rf_rb;
  logic [4:0]  dbg_idx = '0;
  logic [31:0] dbg_data;
  logic [15:0] rf_wcnt;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  reg_file #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cu_rs   (cu_rs),
    .cu_rt   (cu_rt),
    .cu_wreg (cu_wreg),
    .cu_wn   (cu_wn),
    .wb_data (wb_data),
    .rf_ra   (rf_ra),
    .rf_rb   (rf_rb),
    .dbg_idx (dbg_idx),
    .dbg_data(dbg_data),
    .rf_wcnt (rf_wcnt)
  );

  // One-cycle write; returns #1 after the committing edge with write enable dropped.
  task automatic do_write(input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    cu_wreg = 1'b1;
    cu_wn   = idx;
    wb_data = data;
    @(posedge clk);
    #1;
    cu_wreg = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (rf_wcnt !== 16'h0000) begin
      $display("FAIL reset_wcnt got=%h exp=0000", rf_wcnt);
      n_mis++;
    end
    for (int i = 0; i < 32; i += 9) begin
      cu_rs = 5'(i); cu_rt = 5'(i); dbg_idx = 5'(i);
      #1;
      n_cmp++;
      if (rf_ra !== 32'h0 || rf_rb !== 32'h0 || dbg_data !== 32'h0) begin
        $display("FAIL reset_read idx=%0d got ra=%h rb=%h dbg=%h exp=0", i, rf_ra, rf_rb,
                 dbg_data);
        n_mis++;
      end
    end
  endtask

  task automatic test_basic();
    do_write(5'd1, 32'h0000000F);
    do_write(5'd2, 32'h8000000C);
    cu_rs = 5'd1; cu_rt = 5'd2;
    #1;
    n_cmp++;
    if (rf_ra !== 32'h0000000F) begin
      $display("FAIL basic_ra got=%h exp=0000000f", rf_ra);
      n_mis++;
    end
    n_cmp++;
    if (rf_rb !== 32'h8000000C) begin
      $display("FAIL basic_rb got=%h exp=8000000c", rf_rb);
      n_mis++;
    end
    n_cmp++;
    if (rf_wcnt !== 16'd2) begin
      $display("FAIL basic_wcnt got=%h exp=0002", rf_wcnt);
      n_mis++;
    end
    // Write enable low must not touch storage or the counter.
    @(negedge clk);
    cu_wreg = 1'b0; cu_wn = 5'd4; wb_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    dbg_idx = 5'd4;
    #1;
    n_cmp++;
    if (dbg_data !== 32'h0 || rf_wcnt !== 16'd2) begin
      $display("FAIL no_wreg got dbg=%h wcnt=%h exp dbg=0 wcnt=0002", dbg_data, rf_wcnt);
      n_mis++;
    end
  endtask

  task automatic test_same_index();
    cu_rs = 5'd2; cu_rt = 5'd2;
    #1;
    n_cmp++;
    if (rf_ra !== 32'h8000000C || rf_rb !== 32'h8000000C) begin
      $display("FAIL same_index got ra=%h rb=%h exp=8000000c", rf_ra, rf_rb);
      n_mis++;
    end
  endtask

  task automatic test_r0();
    do_write(5'd0, 32'hDEADBEEF);
    cu_rs = 5'd0; cu_rt = 5'd0; dbg_idx = 5'd0;
    #1;
    n_cmp++;
    if (rf_ra !== 32'h0 || rf_rb !== 32'h0 || dbg_data !== 32'h0) begin
      $display("FAIL r0_read got ra=%h rb=%h dbg=%h exp=0", rf_ra, rf_rb, dbg_data);
      n_mis++;
    end
    n_cmp++;
    if (rf_wcnt !== 16'd2) begin
      $display("FAIL r0_wcnt got=%h exp=0002", rf_wcnt);
      n_mis++;
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
`ifdef RF_BYPASS_EN
    exp_same = 32'h22222222;
`else
    exp_same = 32'h11111111;
`endif
    do_write(5'd5, 32'h11111111);
    @(negedge clk);
    cu_rs = 5'd5; cu_rt = 5'd5; dbg_idx = 5'd5;
    cu_wreg = 1'b1; cu_wn = 5'd5; wb_data = 32'h22222222;
    #1;
    n_cmp++;
    if (rf_ra !== exp_same || rf_rb !== exp_same) begin
      $display("FAIL bypass_same_cycle got ra=%h rb=%h exp=%h", rf_ra, rf_rb, exp_same);
      n_mis++;
    end
    n_cmp++;
    if (dbg_data !== 32'h11111111) begin
      $display("FAIL bypass_dbg got=%h exp=11111111", dbg_data);
      n_mis++;
    end
    @(posedge clk);
    #1;
    cu_wreg = 1'b0;
    #1;
    n_cmp++;
    if (rf_ra !== 32'h22222222 || dbg_data !== 32'h22222222) begin
      $display("FAIL bypass_next got ra=%h dbg=%h exp=22222222", rf_ra, dbg_data);
      n_mis++;
    end
    n_cmp++;
    if (rf_wcnt !== 16'd4) begin
      $display("FAIL bypass_wcnt got=%h exp=0004", rf_wcnt);
      n_mis++;
    end
  endtask

  task automatic test_reset_mid();
    do_write(5'd31, 32'hFFFFFFFF);
    dbg_idx = 5'd31;
    #1;
    n_cmp++;
    if (dbg_data !== 32'hFFFFFFFF) begin
      $display("FAIL r31_load got=%h exp=ffffffff", dbg_data);
      n_mis++;
    end
    @(negedge clk);
    rst = 1'b1; cu_wreg = 1'b1; cu_wn = 5'd3; wb_data = 32'h12345678;
    @(posedge clk);
    #1;
    rst = 1'b0; cu_wreg = 1'b0;
    cu_rs = 5'd31; cu_rt = 5'd3; dbg_idx = 5'd3;
    #1;
    n_cmp++;
    if (rf_ra !== 32'h0 || rf_rb !== 32'h0 || dbg_data !== 32'h0 || rf_wcnt !== 16'h0) begin
      $display("FAIL reset_mid got r31=%h r3=%h dbg=%h wcnt=%h exp all 0", rf_ra, rf_rb,
               dbg_data, rf_wcnt);
      n_mis++;
    end
    do_write(5'd3, 32'h000000A5);
    #1;
    n_cmp++;
    if (dbg_data !== 32'h000000A5 || rf_wcnt !== 16'd1) begin
      $display("FAIL post_reset_write got r3=%h wcnt=%h exp r3=000000a5 wcnt=0001", dbg_data,
               rf_wcnt);
      n_mis++;
    end
  endtask

  task automatic test_sweep();
    for (int i = 1; i < 32; i++) begin
      do_write(5'(i), 32'hC0DE0000 + 32'(i) * 32'h00010001);
    end
    for (int i = 0; i < 32; i++) begin
      logic [31:0] exp;
      exp = (i == 0) ? 32'h0 : 32'hC0DE0000 + 32'(i) * 32'h00010001;
      dbg_idx = 5'(i);
      #1;
      n_cmp++;
      if (dbg_data !== exp) begin
        $display("FAIL sweep idx=%0d got=%h exp=%h", i, dbg_data, exp);
        n_mis++;
      end
    end
    n_cmp++;
    if (rf_wcnt !== 16'd32) begin
      $display("FAIL sweep_wcnt got=%h exp=0020", rf_wcnt);
      n_mis++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 65537; i++) begin
      do_write(5'd7, 32'(i));
      if (i == 65535) begin
        n_cmp++;
        if (rf_wcnt !== 16'hFFFF) begin
          $display("FAIL wrap_max got=%h exp=ffff", rf_wcnt);
          n_mis++;
        end
      end
      if (i == 65536) begin
        n_cmp++;
        if (rf_wcnt !== 16'h0000) begin
          $display("FAIL wrap_zero got=%h exp=0000", rf_wcnt);
          n_mis++;
        end
      end
    end
    dbg_idx = 5'd7;
    #1;
    n_cmp++;
    if (rf_wcnt !== 16'h0001) begin
      $display("FAIL wrap_wcnt got=%h exp=0001", rf_wcnt);
      n_mis++;
    end
    n_cmp++;
    if (dbg_data !== 32'h00010001) begin
      $display("FAIL wrap_r7 got=%h exp=00010001", dbg_data);
      n_mis++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_index();
    test_r0();
    test_bypass();
    test_reset_mid();
    test_sweep();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
